// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM encoding and width helpers.
package div_pkg;

    // Widest operand the MIN helper can express.
    localparam int unsigned MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    // Most negative two's-complement value of a given width, right-aligned.
    function automatic logic [MAX_WIDTH-1:0] min_val(input int unsigned width);
        return {{(MAX_WIDTH-1){1'b0}}, 1'b1} << (width - 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0]   part;
    logic [WIDTH-1:0] diff;

    // Shift in the next dividend bit, then subtract the divisor when it fits.
    // rem_i < dvs_i, so the true difference always fits in WIDTH bits.
    always_comb begin
        part  = {rem_i, bit_i};
        diff  = part[WIDTH-1:0] - dvs_i;
        q_o   = (part >= {1'b0, dvs_i});
        rem_o = q_o ? diff : part[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider, signed/unsigned, one quotient bit per clock.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int unsigned      CW    = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(min_val(WIDTH));
    localparam logic [WIDTH-1:0] ONES  = {WIDTH{1'b1}};

    state_e state_q, state_d;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sgn_q, sgn_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] dvs_mag_q, dvs_mag_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_out_q, dbz_out_d;
    logic             ovf_q, ovf_d;

    logic             sgn_in;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] step_rem;
    logic             step_bit;

    // Operand magnitudes; MIN negates onto itself, which reads as 2^(WIDTH-1) unsigned.
    always_comb begin
        sgn_in  = signed_mode & SIGNED_EN;
        dvd_mag = (sgn_in && dividend[WIDTH-1]) ? (~dividend + WIDTH'(1)) : dividend;
        dvs_mag = (sgn_in && divisor[WIDTH-1])  ? (~divisor  + WIDTH'(1)) : divisor;
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (prem_q),
        .bit_i (shift_q[WIDTH-1]),
        .dvs_i (dvs_mag_q),
        .rem_o (step_rem),
        .q_o   (step_bit)
    );

    // Next-state and datapath update for IDLE / CALC / FIX.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sgn_d     = sgn_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        dbz_d     = dbz_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        dvs_mag_d = dvs_mag_q;
        shift_d   = shift_q;
        prem_d    = prem_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dbz_out_d = dbz_out_q;
        ovf_d     = ovf_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dvd_d     = dividend;
                    dvs_d     = divisor;
                    sgn_d     = sgn_in;
                    dvs_mag_d = dvs_mag;
                    shift_d   = dvd_mag;
                    prem_d    = '0;
                    qneg_d    = sgn_in & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    rneg_d    = sgn_in & dividend[WIDTH-1];
                    busy_d    = 1'b1;
                    if (divisor == '0) begin
                        dbz_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_FIX;
                    end else begin
                        dbz_d   = 1'b0;
                        cnt_d   = CW'(WIDTH);
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                prem_d  = step_rem;
                shift_d = {shift_q[WIDTH-2:0], step_bit};
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (dbz_q) begin
                    quot_d = ONES;
                    rem_d  = dvd_q;
                end else begin
                    quot_d = qneg_q ? (~shift_q + WIDTH'(1)) : shift_q;
                    rem_d  = rneg_q ? (~prem_q + WIDTH'(1)) : prem_q;
                end
                dbz_out_d = dbz_q;
                ovf_d     = sgn_q & (dvd_q == MIN_V) & (dvs_q == ONES);
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand, iteration and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            sgn_q     <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            dbz_q     <= 1'b0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            dvs_mag_q <= '0;
            shift_q   <= '0;
            prem_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            dbz_out_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            sgn_q     <= sgn_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            dbz_q     <= dbz_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            dvs_mag_q <= dvs_mag_d;
            shift_q   <= shift_d;
            prem_q    <= prem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            dbz_out_q <= dbz_out_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_out_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: arithmetic reference model compared every cycle, plus directed literals.
module tb_seq_divider;

    localparam int unsigned W = 32;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic         signed_mode;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;

    logic         busy   [2];
    logic         done   [2];
    logic [W-1:0] quot   [2];
    logic [W-1:0] rem    [2];
    logic         dbz    [2];
    logic         ovf    [2];

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    // Instance 0 honours signed_mode; instance 1 is built unsigned-only.
    seq_divider #(.WIDTH(W), .SIGNED_EN(1'b1)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .signed_mode(signed_mode),
        .dividend(dividend), .divisor(divisor),
        .busy(busy[0]), .done(done[0]), .quotient(quot[0]), .remainder(rem[0]),
        .div_by_zero(dbz[0]), .overflow(ovf[0])
    );

    seq_divider #(.WIDTH(W), .SIGNED_EN(1'b0)) u_dut_us (
        .clk(clk), .reset_n(reset_n), .start(start), .signed_mode(signed_mode),
        .dividend(dividend), .divisor(divisor),
        .busy(busy[1]), .done(done[1]), .quotient(quot[1]), .remainder(rem[1]),
        .div_by_zero(dbz[1]), .overflow(ovf[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference division from plain integer arithmetic: {quotient, remainder, dbz, ovf}.
    function automatic logic [2*W+1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
        longint       sa;
        longint       sb;
        logic [W-1:0] q;
        logic [W-1:0] r;
        bit           v;
        if (b == '0) return {32'hFFFF_FFFF, a, 1'b1, 1'b0};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            v  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
            v  = 1'b0;
        end
        q = W'(sa / sb);
        r = W'(sa % sb);
        return {q, r, 1'b0, v};
    endfunction

    // Transaction-level model: accept when idle, report after the expected number of edges.
    logic [2*W+1:0] m_pend [2];
    logic [2*W+1:0] m_res  [2];
    bit             m_busy [2];
    bit             m_done [2];
    int             m_cnt  [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = '0; m_res[k] = '0; m_busy[k] = 1'b0; m_done[k] = 1'b0; m_cnt[k] = 0;
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                m_pend[k] <= '0; m_res[k] <= '0; m_busy[k] <= 1'b0; m_done[k] <= 1'b0; m_cnt[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_done[k] <= 1'b0;
                if (m_busy[k]) begin
                    m_cnt[k] <= m_cnt[k] - 1;
                    if (m_cnt[k] == 1) begin
                        m_busy[k] <= 1'b0;
                        m_done[k] <= 1'b1;
                        m_res[k]  <= m_pend[k];
                    end
                end else if (start) begin
                    m_pend[k] <= ref_div(dividend, divisor, (k == 0) && signed_mode);
                    m_cnt[k]  <= (divisor == '0) ? 1 : W + 1;
                    m_busy[k] <= 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("u%0d_busy", k), W'(busy[k]), W'(m_busy[k]));
                check($sformatf("u%0d_done", k), W'(done[k]), W'(m_done[k]));
                check($sformatf("u%0d_quot", k), quot[k], m_res[k][2*W+1:W+2]);
                check($sformatf("u%0d_rem", k),  rem[k],  m_res[k][W+1:2]);
                check($sformatf("u%0d_dbz", k),  W'(dbz[k]), W'(m_res[k][1]));
                check($sformatf("u%0d_ovf", k),  W'(ovf[k]), W'(m_res[k][0]));
            end
        end
    end

    // Called just after a posedge; the request is sampled on the following edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit sm);
        start       = 1'b1;
        dividend    = a;
        divisor     = b;
        signed_mode = sm;
    endtask

    // Wait for done, scrambling operands after acceptance and optionally re-pulsing start while busy.
    task automatic wait_done(input string tag, input int exp_n, input int inj_at);
        int n;
        n = 0;
        do begin
            @(posedge clk); #2;
            n++;
            if (n == 1) begin
                start       = 1'b0;
                dividend    = 32'hDEAD_BEEF;
                divisor     = 32'h0BAD_F00D;
                signed_mode = ~signed_mode;
            end
            if (inj_at != 0 && n == inj_at) begin
                start = 1'b1; dividend = 32'd9; divisor = 32'd3;
            end
            if (inj_at != 0 && n == inj_at + 1) start = 1'b0;
        end while (!done[0] && n < 200);
        check({tag, "_lat"}, W'(n), W'(exp_n));
    endtask

    task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input bit sm,
                      input logic [W-1:0] eq, input logic [W-1:0] er, input bit ed, input bit ev,
                      input int exp_n, input int inj_at);
        start_op(a, b, sm);
        wait_done(tag, exp_n, inj_at);
        check({tag, "_q"},   quot[0], eq);
        check({tag, "_r"},   rem[0],  er);
        check({tag, "_dbz"}, W'(dbz[0]), W'(ed));
        check({tag, "_ovf"}, W'(ovf[0]), W'(ev));
    endtask

    localparam int NORM = W + 2;
    localparam int ZLAT = 2;

    initial begin
        reset_n = 1'b1; start = 1'b0; signed_mode = 1'b0; dividend = '0; divisor = '0;
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        for (int k = 0; k < 2; k++) begin
            check("rst_busy", W'(busy[k]), '0);
            check("rst_done", W'(done[k]), '0);
            check("rst_q", quot[k], '0);
            check("rst_r", rem[k], '0);
        end
        cmp_en  = 1'b1;
        reset_n = 1'b1;
        @(posedge clk); #2;

        op("u100_7",  32'd100,       32'd7, 1'b0, 32'd14,        32'd2,        1'b0, 1'b0, NORM, 0);
        op("s-100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, NORM, 0);
        op("u9C_7",   32'hFFFF_FF9C, 32'd7, 1'b0, 32'h2492_4916, 32'd2,        1'b0, 1'b0, NORM, 0);
        op("s7_-2",   32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,        1'b0, 1'b0, NORM, 0);
        op("dbz",     32'h1234,      32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234,     1'b1, 1'b0, ZLAT, 0);
        op("clr",     32'd100,       32'd7, 1'b0, 32'd14,        32'd2,        1'b0, 1'b0, NORM, 0);
        op("sdbz",    32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1'b0, ZLAT, 0);
        op("ovf",     32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 1'b1, NORM, 0);
        check("ovf_us_q",   quot[1], 32'd0);
        check("ovf_us_r",   rem[1],  32'h8000_0000);
        check("ovf_us_ovf", W'(ovf[1]), '0);

        // Second start while busy is ignored; a start in the done cycle is accepted.
        op("busy_ign", 32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 1'b0, NORM, 6);
        op("b2b",      32'd9,    32'd3,  1'b0, 32'd3,   32'd0, 1'b0, 1'b0, NORM, 0);

        // Reset in the middle of an operation.
        @(posedge clk); #2;
        start_op(32'hFFFF_FFFF, 32'd3, 1'b0);
        repeat (11) begin
            @(posedge clk); #2;
            start = 1'b0;
        end
        check("pre_rst_busy", W'(busy[0]), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", W'(busy[0]), '0);
        check("mid_rst_done", W'(done[0]), '0);
        check("mid_rst_q",    quot[0], '0);
        check("mid_rst_r",    rem[0],  '0);
        check("mid_rst_dbz",  W'(dbz[0]), '0);
        check("mid_rst_ovf",  W'(ovf[0]), '0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (40) @(posedge clk);
        #2;
        op("fresh", 32'hFFFF_FFFF, 32'd3, 1'b0, 32'h5555_5555, 32'd0, 1'b0, 1'b0, NORM, 0);

        repeat (3) @(posedge clk);
        #2;
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
